// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges the icache (master 0) and dcache (master 1) cbus
// request streams onto the single cbus port toward memory. A grant is held
// for a whole transaction (single or burst) until the beat carrying
// ready && last, then the arbiter drops back to IDLE and re-arbitrates.
//
// Optional feature macro: CBUS_ARB_RR_EN
//   defined     -> round-robin on conflicts (last-served register built)
//   not defined -> fixed priority, master DEFAULT_PRIO wins conflicts

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int DEFAULT_PRIO = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    input  cbus_req_t  dreq,
    output cbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   sel_reg;
    logic   sel_next;
    logic   any_valid;
    logic   winner;

`ifdef CBUS_ARB_RR_EN
    // Index of the master granted most recently; the other one wins a tie.
    logic   last_reg;
`else
    localparam logic PRIO_SEL = (DEFAULT_PRIO != 0);
`endif

    // Pick the winner among the currently requesting masters.
    always_comb begin
        any_valid = ireq.valid | dreq.valid;
        winner    = dreq.valid;
        if (ireq.valid && dreq.valid) begin
`ifdef CBUS_ARB_RR_EN
            winner = ~last_reg;
`else
            winner = PRIO_SEL;
`endif
        end
    end

    // Next-state logic: grant on any request, release on the final beat.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    state_next = GRANT;
                    sel_next   = winner;
                end
            end
            GRANT: begin
                if (oresp.ready && oresp.last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output routing: only the granted master sees memory; all else is zero.
    // oreq depends on state/sel/requests only, never on oresp.
    always_comb begin
        oreq  = '0;
        iresp = '0;
        dresp = '0;
        if (state_reg == GRANT) begin
            if (sel_reg) begin
                oreq  = dreq;
                dresp = oresp;
            end else begin
                oreq  = ireq;
                iresp = oresp;
            end
        end
    end

    // State and grant registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

`ifdef CBUS_ARB_RR_EN
    // Last-served tracker, updated only when a new grant is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_reg <= 1'b1;
        end else if (state_reg == IDLE && any_valid) begin
            last_reg <= winner;
        end
    end
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Testbench for cbus_arbiter: directed transactions with a scoreboard.
// Stimulus pushes the expected per-beat master responses into a queue; a
// negedge monitor pops and compares whenever either master sees ready.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    typedef struct {
        bit          m;
        logic [63:0] data;
        bit          last;
    } exp_t;

    logic       clk;
    logic       reset;
    cbus_req_t  ireq;
    cbus_resp_t iresp;
    cbus_req_t  dreq;
    cbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];

    cbus_arbiter #(.DEFAULT_PRIO(1)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready seen by a master must match the next expected beat.
    always @(negedge clk) begin
        if (iresp.ready || dresp.ready) begin
            check("both_ready", {63'd0, iresp.ready & dresp.ready}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {63'd0, dresp.ready}, {63'd0, ~dresp.ready});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_master", {63'd0, dresp.ready}, {63'd0, e.m});
                check("resp_data", dresp.ready ? dresp.data : iresp.data, e.data);
                check("resp_last", {63'd0, dresp.ready ? dresp.last : iresp.last}, {63'd0, e.last});
                check("other_resp_data", dresp.ready ? iresp.data : dresp.data, 64'd0);
            end
        end
    end

    task automatic set_req(input bit m, input bit wr, input logic [31:0] addr,
                           input logic [7:0] len, input logic [7:0] strobe);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd3;
        r.addr     = addr;
        r.strobe   = strobe;
        r.data     = 64'hA5A5_0000_0000_0000 | {32'd0, addr};
        r.len      = len;
        r.burst    = (len != 0) ? 2'd1 : 2'd0;
        if (m) dreq = r;
        else   ireq = r;
    endtask

    // Wait (bounded) for the grant and check latency and routed request.
    task automatic wait_grant(input bit m, input int exp_lat, output bit ok);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!oreq.valid && cnt < 10);
        check("grant_latency", cnt, exp_lat);
        ok = oreq.valid;
        if (ok) begin
            check("grant_addr", oreq.addr, m ? dreq.addr : ireq.addr);
            check("grant_is_write", {63'd0, oreq.is_write}, {63'd0, m ? dreq.is_write : ireq.is_write});
        end
    endtask

    // Serve one transaction of nbeats from memory; drop is a {d,i} valid-clear mask.
    task automatic serve(input bit m, input int nbeats, input int exp_lat,
                         input logic [63:0] data0, input logic [1:0] drop);
        bit ok;
        wait_grant(m, exp_lat, ok);
        if (!ok) return;
        for (int b = 0; b < nbeats; b++) begin
            exp_t e;
            oresp.ready = 1'b1;
            oresp.last  = (b == nbeats - 1);
            oresp.data  = data0 + 64'(b);
            e.m    = m;
            e.data = data0 + 64'(b);
            e.last = (b == nbeats - 1);
            exp_q.push_back(e);
            check("beat_is_write", {63'd0, oreq.is_write}, {63'd0, m ? dreq.is_write : ireq.is_write});
            @(posedge clk);
            #1;
        end
        oresp = '0;
        if (drop[0]) ireq.valid = 1'b0;
        if (drop[1]) dreq.valid = 1'b0;
        check("idle_after_last", {63'd0, oreq.valid}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b0;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_oreq", 64'(oreq), 64'd0);
        check("reset_iresp_ready", {63'd0, iresp.ready}, 64'd0);
        check("reset_dresp_ready", {63'd0, dresp.ready}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single icache read.
        set_req(0, 1'b0, 32'h8000_0000, 8'd0, 8'h00);
        serve(0, 1, 1, 64'h1234_5678, 2'b01);
        @(posedge clk);
        #1;

        // dcache write burst, 4 beats.
        set_req(1, 1'b1, 32'h4000_0100, 8'd3, 8'hFF);
        wait_grant(1, 1, ok);
        check("burst_strobe", {56'd0, oreq.strobe}, 64'hFF);
        for (int b = 0; b < 4; b++) begin
            exp_t e;
            oresp.ready = 1'b1;
            oresp.last  = (b == 3);
            oresp.data  = 64'hD000 + 64'(b);
            e.m = 1'b1; e.data = 64'hD000 + 64'(b); e.last = (b == 3);
            exp_q.push_back(e);
            check("burst_is_write", {63'd0, oreq.is_write}, 64'd1);
            check("burst_held", {63'd0, oreq.valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        oresp = '0;
        dreq.valid = 1'b0;
        check("burst_released", {63'd0, oreq.valid}, 64'd0);
        @(posedge clk);
        #1;

        // Conflict: both requests raised in the same cycle.
        set_req(0, 1'b0, 32'h8000_0040, 8'd0, 8'h00);
        set_req(1, 1'b0, 32'h4000_0200, 8'd1, 8'h00);
`ifdef CBUS_ARB_RR_EN
        serve(0, 1, 1, 64'hC100, 2'b01);
        serve(1, 2, 1, 64'hC200, 2'b10);
`else
        serve(1, 2, 1, 64'hC200, 2'b10);
        serve(0, 1, 1, 64'hC100, 2'b01);
`endif
        @(posedge clk);
        #1;

        // Reset during beat 2 of a 4-beat icache burst.
        set_req(0, 1'b0, 32'h8000_1000, 8'd3, 8'h00);
        wait_grant(0, 1, ok);
        begin
            exp_t e;
            oresp.ready = 1'b1; oresp.last = 1'b0; oresp.data = 64'hB0;
            e.m = 1'b0; e.data = 64'hB0; e.last = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        reset       = 1'b0;
        oresp.data  = 64'hB1;
        #1;
        check("rst_oreq_valid", {63'd0, oreq.valid}, 64'd0);
        check("rst_iresp_ready", {63'd0, iresp.ready}, 64'd0);
        check("rst_dresp_ready", {63'd0, dresp.ready}, 64'd0);
        ireq.valid = 1'b0;
        set_req(1, 1'b0, 32'h4000_0300, 8'd0, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_idle", {63'd0, oreq.valid}, 64'd0);
        oresp = '0;
        reset = 1'b1;
        serve(1, 1, 1, 64'hE000, 2'b10);
        @(posedge clk);
        #1;

        // Spurious memory ready while idle.
        oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'hDEAD;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("spur_oreq_valid", {63'd0, oreq.valid}, 64'd0);
            check("spur_ready", {62'd0, iresp.ready, dresp.ready}, 64'd0);
        end
        oresp = '0;
        set_req(0, 1'b0, 32'h8000_2000, 8'd0, 8'h00);
        serve(0, 1, 1, 64'hF00D, 2'b01);
        @(posedge clk);
        #1;

        // Both masters continuously valid for six single transfers, fresh reset.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_req(0, 1'b0, 32'h8000_3000, 8'd0, 8'h00);
        set_req(1, 1'b0, 32'h4000_3000, 8'd0, 8'h00);
        for (int k = 0; k < 6; k++) begin
`ifdef CBUS_ARB_RR_EN
            serve(k[0], 1, 1, 64'h600 + 64'(k), (k == 5) ? 2'b11 : 2'b00);
`else
            serve(1'b1, 1, 1, 64'h600 + 64'(k), (k == 5) ? 2'b11 : 2'b00);
`endif
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
